cv_tile_scheduler: RTL

- Layer-level sequencer for the convolution engine: splits one conv layer into tiles and drives the data loader's load_weight / load_input / store_output commands, along with per-tile extent and origin values.
- Starts PE compute and waits on pe_idle between loader commands.
- Sits between the instruction decoder (start/done) and the data loader/PE.

---
 rtl/cv_tile_scheduler.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv_tile_scheduler.sv
// Layer-level tile sequencer for the conv engine: walks O/H/W/I tiles and drives loader/PE.
// Optional: define CV_SCHED_WEIGHT_REUSE_EN to skip reloading resident weights.
module cv_tile_scheduler #(
    parameter int TILE_I  = 16,
    parameter int TILE_O  = 16,
    parameter int TILE_HO = 8,
    parameter int TILE_WO = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] I,
    input  logic [10:0] O,
    input  logic [10:0] H,
    input  logic [10:0] W,
    input  logic [4:0]  K,
    output logic        busy,
    output logic        layer_done,
    output logic        load_weight,
    output logic        load_input,
    output logic        store_output,
    input  logic        ld_done,
    output logic [10:0] Iext,
    output logic [10:0] Oext,
    output logic [10:0] Hext,
    output logic [10:0] Wext,
    output logic [10:0] Iori,
    output logic [10:0] Oori,
    output logic [10:0] Hori,
    output logic [10:0] Wori,
    output logic        pe_start,
    output logic        pe_acc_clear,
    input  logic        pe_idle
);

    localparam logic [10:0] T_I  = 11'(TILE_I);
    localparam logic [10:0] T_O  = 11'(TILE_O);
    localparam logic [10:0] T_HO = 11'(TILE_HO);
    localparam logic [10:0] T_WO = 11'(TILE_WO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LW,
        S_LIF,
        S_RUN,
        S_WPE,
        S_SOF,
        S_NXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_q, cmd_d;
    logic        guard_q, guard_d;
    logic [10:0] i_q, i_d, o_q, o_d, h_q, h_d, w_q, w_d;
    logic [4:0]  k_q, k_d;
    logic [10:0] iori_q, iori_d, oori_q, oori_d;
    logic [10:0] hori_q, hori_d, wori_q, wori_d;
    logic [10:0] iext_q, iext_d, oext_q, oext_d;
    logic [10:0] hext_q, hext_d, wext_q, wext_d;

    logic        ld_ext;
    logic        o_adv;
    logic        last_tile;
    logic        reuse_ok;
    logic [10:0] km1_c, ho_c, wo_c;
    logic [10:0] km1_n, ho_n, wo_n;
    logic [11:0] i_end, o_end, h_end, w_end;
    logic        i_more, o_wrap, h_wrap, w_wrap;

    function automatic logic [10:0] min11(input logic [10:0] a,
                                          input logic [10:0] b);
        return (a < b) ? a : b;
    endfunction

    // Output-side sizes of the latched layer and of the layer being latched
    assign km1_c = {6'b0, k_q} - 11'd1;
    assign ho_c  = h_q - km1_c;
    assign wo_c  = w_q - km1_c;
    assign km1_n = {6'b0, k_d} - 11'd1;
    assign ho_n  = h_d - km1_n;
    assign wo_n  = w_d - km1_n;

    assign i_end  = {1'b0, iori_q} + {1'b0, iext_q};
    assign o_end  = {1'b0, oori_q} + {1'b0, oext_q};
    assign h_end  = {1'b0, hori_q} + {1'b0, min11(T_HO, ho_c - hori_q)};
    assign w_end  = {1'b0, wori_q} + {1'b0, min11(T_WO, wo_c - wori_q)};
    assign i_more = i_end < {1'b0, i_q};
    assign o_wrap = o_end >= {1'b0, o_q};
    assign h_wrap = h_end >= {1'b0, ho_c};
    assign w_wrap = w_end >= {1'b0, wo_c};

`ifdef CV_SCHED_WEIGHT_REUSE_EN
    assign reuse_ok = (i_q <= T_I);
`else
    assign reuse_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            guard_q <= 1'b0;
            i_q     <= '0;
            o_q     <= '0;
            h_q     <= '0;
            w_q     <= '0;
            k_q     <= '0;
            iori_q  <= '0;
            oori_q  <= '0;
            hori_q  <= '0;
            wori_q  <= '0;
            iext_q  <= '0;
            oext_q  <= '0;
            hext_q  <= '0;
            wext_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            guard_q <= guard_d;
            i_q     <= i_d;
            o_q     <= o_d;
            h_q     <= h_d;
            w_q     <= w_d;
            k_q     <= k_d;
            iori_q  <= iori_d;
            oori_q  <= oori_d;
            hori_q  <= hori_d;
            wori_q  <= wori_d;
            iext_q  <= iext_d;
            oext_q  <= oext_d;
            hext_q  <= hext_d;
            wext_q  <= wext_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        guard_d   = guard_q;
        i_d       = i_q;
        o_d       = o_q;
        h_d       = h_q;
        w_d       = w_q;
        k_d       = k_q;
        iori_d    = iori_q;
        oori_d    = oori_q;
        hori_d    = hori_q;
        wori_d    = wori_q;
        ld_ext    = 1'b0;
        o_adv     = 1'b0;
        last_tile = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = I;
                    o_d     = O;
                    h_d     = H;
                    w_d     = W;
                    k_d     = K;
                    iori_d  = '0;
                    oori_d  = '0;
                    hori_d  = '0;
                    wori_d  = '0;
                    ld_ext  = 1'b1;
                    state_d = S_LW;
                end
            end
            S_LW: begin
                if (!cmd_q) begin
                    cmd_d = pe_idle;
                end else if (ld_done) begin
                    cmd_d   = 1'b0;
                    state_d = S_LIF;
                end
            end
            S_LIF: begin
                if (!cmd_q) begin
                    cmd_d = pe_idle;
                end else if (ld_done) begin
                    cmd_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                guard_d = 1'b1;
                state_d = S_WPE;
            end
            S_WPE: begin
                // pe_idle may still read 1 the cycle after pe_start
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (pe_idle) begin
                    if (i_more) begin
                        iori_d  = iori_q + T_I;
                        ld_ext  = 1'b1;
                        state_d = S_LW;
                    end else begin
                        state_d = S_SOF;
                    end
                end
            end
            S_SOF: begin
                if (!cmd_q) begin
                    cmd_d = pe_idle;
                end else if (ld_done) begin
                    cmd_d   = 1'b0;
                    state_d = S_NXT;
                end
            end
            S_NXT: begin
                iori_d = '0;
                ld_ext = 1'b1;
                if (!w_wrap) begin
                    wori_d = wori_q + T_WO;
                end else begin
                    wori_d = '0;
                    if (!h_wrap) begin
                        hori_d = hori_q + T_HO;
                    end else begin
                        hori_d = '0;
                        if (!o_wrap) begin
                            oori_d = oori_q + T_O;
                            o_adv  = 1'b1;
                        end else begin
                            oori_d    = '0;
                            last_tile = 1'b1;
                        end
                    end
                end
                if (last_tile) begin
                    state_d = S_DONE;
                end else if (reuse_ok && !o_adv) begin
                    state_d = S_LIF;
                end else begin
                    state_d = S_LW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        iext_d = iext_q;
        oext_d = oext_q;
        hext_d = hext_q;
        wext_d = wext_q;
        if (ld_ext) begin
            iext_d = min11(T_I, i_d - iori_d);
            oext_d = min11(T_O, o_d - oori_d);
            hext_d = min11(T_HO, ho_n - hori_d) + km1_n;
            wext_d = min11(T_WO, wo_n - wori_d) + km1_n;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign layer_done   = (state_q == S_DONE);
    assign load_weight  = (state_q == S_LW) && cmd_q;
    assign load_input   = (state_q == S_LIF) && cmd_q;
    assign store_output = (state_q == S_SOF) && cmd_q;
    assign pe_start     = (state_q == S_RUN);
    assign pe_acc_clear = pe_start && (iori_q == 11'd0);

    assign Iext = iext_q;
    assign Oext = oext_q;
    assign Hext = hext_q;
    assign Wext = wext_q;
    assign Iori = iori_q;
    assign Oori = oori_q;
    assign Hori = hori_q;
    assign Wori = wori_q;

endmodule
